// File: rtl/hdmi_audio_pkg.sv
// Shared helpers for the HDMI audio pacer: accumulator increment, level width
// and per-channel sample width conversion.
// Latency: n/a (pure functions). Backpressure: n/a.
// Contents: audio_inc(), level_w(), widen_sample().
package hdmi_audio_pkg;

  // The accumulator advances by twice the sample rate because clk_audio
  // toggles on every wrap and a full clk_audio period needs two wraps.
  function automatic int unsigned audio_inc(input int unsigned rate);
    return 2 * rate;
  endfunction

  // Width of a 0..depth occupancy counter.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Two's complement width change on one channel. The caller zero-extends the
  // sample into 32 bits and keeps the low out_w bits of the result. Widening
  // left-justifies (zero LSB pad); narrowing keeps the MSBs with no rounding.
  function automatic logic [31:0] widen_sample(input logic [31:0] smp,
                                               input int          in_w,
                                               input int          out_w);
    logic [31:0] res;
    res = smp;
    if (out_w > in_w) begin
      res = smp << (out_w - in_w);
    end else if (out_w < in_w) begin
      res = smp >> (in_w - out_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with registered occupancy and first-word fall-through head.
// Latency: a pushed word is visible on head_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: clk_pixel, reset (sync, high), push/push_dat, pop, head_dat, full, empty, level.
module audio_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("audio_frame_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (PTR_W + 1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Pointers are exactly PTR_W bits wide, so natural overflow wraps them
  // modulo DEPTH.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: reset clears the pointers, which discards contents.
  always_ff @(posedge clk_pixel) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/hdmi_audio_pacer.sv
// Fractional-accumulator audio clock plus frame FIFO feeding the HDMI encoder.
// Latency: a frame pushed at edge n can appear on audio_out at the first tick at edge >= n+1.
// Backpressure: in_ready drops when the FIFO is full; a frame offered then is dropped and flagged.
// Ports: clk_pixel, reset (sync, high); in_valid/in_data/in_ready input frames; mute, clr_flags;
//        clk_audio, sample_tick, audio_out to the encoder; fifo_level, underrun, overflow status.
module hdmi_audio_pacer
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned PIXEL_CLOCK   = 40000000,
  parameter int unsigned AUDIO_RATE    = 48000,
  parameter int          CHANNELS      = 2,
  parameter int          IN_WIDTH      = 16,
  parameter int          OUT_WIDTH     = 16,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          ACC_WIDTH     = 32,
  parameter bit          UNDERRUN_ZERO = 1'b0
) (
  input  logic                              clk_pixel,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [CHANNELS*IN_WIDTH-1:0]      in_data,
  output logic                              in_ready,
  input  logic                              mute,
  input  logic                              clr_flags,
  output logic                              clk_audio,
  output logic                              sample_tick,
  output logic [CHANNELS*OUT_WIDTH-1:0]     audio_out,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              underrun,
  output logic                              overflow
);

  localparam int unsigned     INC     = audio_inc(AUDIO_RATE);
  localparam int              LEVEL_W = level_w(FIFO_DEPTH);
  localparam int              IN_FW   = CHANNELS * IN_WIDTH;
  localparam int              OUT_FW  = CHANNELS * OUT_WIDTH;
  localparam longint unsigned ACC_SPAN =
    (ACC_WIDTH >= 63) ? 64'h7FFF_FFFF_FFFF_FFFF : (64'd1 << ACC_WIDTH);

  if (INC >= PIXEL_CLOCK) begin : g_bad_rate
    $error("hdmi_audio_pacer: 2*AUDIO_RATE must be below PIXEL_CLOCK");
  end
  if (ACC_SPAN <= (64'(PIXEL_CLOCK) + 64'(INC))) begin : g_bad_acc
    $error("hdmi_audio_pacer: ACC_WIDTH too small for PIXEL_CLOCK + 2*AUDIO_RATE");
  end
  if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_ch
    $error("hdmi_audio_pacer: CHANNELS must be 1..8");
  end
  if ((OUT_WIDTH < 16) || (OUT_WIDTH > 24) || (IN_WIDTH < 1) || (IN_WIDTH > 32)) begin : g_bad_w
    $error("hdmi_audio_pacer: OUT_WIDTH must be 16..24 and IN_WIDTH 1..32");
  end

  // One extra bit so acc + INC never overflows before the compare.
  localparam logic [ACC_WIDTH:0] INC_V = (ACC_WIDTH + 1)'(INC);
  localparam logic [ACC_WIDTH:0] PC_V  = (ACC_WIDTH + 1)'(PIXEL_CLOCK);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH:0]   acc_nxt;
  logic                 wrap;
  logic                 tick;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 do_push;
  logic                 do_pop;
  logic [IN_FW-1:0]     head_dat;
  logic [OUT_FW-1:0]    head_wide;
  logic [OUT_FW-1:0]    last_frame;
  logic [OUT_FW-1:0]    sel_frame;
  logic [LEVEL_W-1:0]   level;

  // Phase accumulator: wraps at PIXEL_CLOCK, so over PIXEL_CLOCK cycles it
  // wraps exactly 2*AUDIO_RATE times.
  assign acc_sum = {1'b0, acc} + INC_V;
  assign wrap    = (acc_sum >= PC_V);
  assign acc_nxt = wrap ? (acc_sum - PC_V) : acc_sum;

  // A tick is a wrap that takes clk_audio from 0 to 1.
  assign tick    = wrap && !clk_audio;

  assign in_ready   = !fifo_full;
  assign do_push    = in_valid && in_ready;
  assign do_pop     = tick && !fifo_empty;
  assign fifo_level = level;

  audio_frame_fifo #(
    .WIDTH (IN_FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .push      (do_push),
    .push_dat  (in_data),
    .pop       (do_pop),
    .head_dat  (head_dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_conv
    logic [31:0] raw;
    assign raw = 32'(head_dat[c*IN_WIDTH +: IN_WIDTH]);
    assign head_wide[c*OUT_WIDTH +: OUT_WIDTH] =
      OUT_WIDTH'(widen_sample(raw, IN_WIDTH, OUT_WIDTH));
  end

  // Mute only blanks the output; the pop still happens so the FIFO drains.
  always_comb begin
    sel_frame = last_frame;
    if (mute) begin
      sel_frame = '0;
    end else if (!fifo_empty) begin
      sel_frame = head_wide;
    end else if (UNDERRUN_ZERO) begin
      sel_frame = '0;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc         <= '0;
      clk_audio   <= 1'b0;
      sample_tick <= 1'b0;
      audio_out   <= '0;
      last_frame  <= '0;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      acc         <= acc_nxt[ACC_WIDTH-1:0];
      sample_tick <= tick;
      if (wrap) clk_audio <= !clk_audio;
      if (tick) begin
        audio_out <= sel_frame;
        if (!fifo_empty) last_frame <= head_wide;
      end
      // Set has priority over clear so no event is lost.
      if (tick && fifo_empty)    underrun <= 1'b1;
      else if (clr_flags)        underrun <= 1'b0;
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (clr_flags)        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// Directed bench for hdmi_audio_pacer: accumulator phase, long-run rate, FIFO
// ordering/width, overflow, underrun, mute and mid-run reset.
// Three instances share inputs: main (100/2 Hz), phase (10/2 Hz), zero-fill.
module tb_hdmi_audio_pacer;

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic        mute      = 1'b0;
  logic        clr_flags = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  // main instance
  logic        m_ready, m_clk, m_tick, m_under, m_over;
  logic [47:0] m_out;
  logic [2:0]  m_level;
  // phase instance
  logic        p_ready, p_clk, p_tick, p_under, p_over;
  logic [47:0] p_out;
  logic [2:0]  p_level;
  // zero-fill instance
  logic        z_ready, z_clk, z_tick, z_under, z_over;
  logic [47:0] z_out;
  logic [2:0]  z_level;

  hdmi_audio_pacer #(
    .PIXEL_CLOCK(100), .AUDIO_RATE(2), .CHANNELS(2), .IN_WIDTH(16),
    .OUT_WIDTH(24), .FIFO_DEPTH(4), .ACC_WIDTH(32), .UNDERRUN_ZERO(1'b0)
  ) u_main (
    .clk_pixel(clk_pixel), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_ready), .mute(mute), .clr_flags(clr_flags), .clk_audio(m_clk),
    .sample_tick(m_tick), .audio_out(m_out), .fifo_level(m_level),
    .underrun(m_under), .overflow(m_over)
  );

  hdmi_audio_pacer #(
    .PIXEL_CLOCK(10), .AUDIO_RATE(2), .CHANNELS(2), .IN_WIDTH(16),
    .OUT_WIDTH(24), .FIFO_DEPTH(4), .ACC_WIDTH(8), .UNDERRUN_ZERO(1'b0)
  ) u_phase (
    .clk_pixel(clk_pixel), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(p_ready), .mute(mute), .clr_flags(clr_flags), .clk_audio(p_clk),
    .sample_tick(p_tick), .audio_out(p_out), .fifo_level(p_level),
    .underrun(p_under), .overflow(p_over)
  );

  hdmi_audio_pacer #(
    .PIXEL_CLOCK(100), .AUDIO_RATE(2), .CHANNELS(2), .IN_WIDTH(16),
    .OUT_WIDTH(24), .FIFO_DEPTH(4), .ACC_WIDTH(32), .UNDERRUN_ZERO(1'b1)
  ) u_zero (
    .clk_pixel(clk_pixel), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(z_ready), .mute(mute), .clr_flags(clr_flags), .clk_audio(z_clk),
    .sample_tick(z_tick), .audio_out(z_out), .fifo_level(z_level),
    .underrun(z_under), .overflow(z_over)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Step until the main instance shows a tick; a missing tick is a failure.
  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_tick) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_tick_seen"}, 64'(seen), 64'd1);
  endtask

  function automatic logic [47:0] w24(input logic [15:0] c1, input logic [15:0] c0);
    return {c1, 8'h00, c0, 8'h00};
  endfunction

  logic [12:0] ph_clk, ph_tick;
  logic        prev_p, prev_m;
  int          p_tog, p_ticks, p_last, p_gap;
  int          m_tog, m_ticks, m_last, m_gap;

  initial begin
    ph_clk = '0; ph_tick = '0;
    prev_p = 1'b0; prev_m = 1'b0;
    p_tog = 0; p_ticks = 0; p_last = 0; p_gap = 0;
    m_tog = 0; m_ticks = 0; m_last = 0; m_gap = 0;

    // ---- reset state
    repeat (3) step();
    chk("rst_clk_audio", 64'(m_clk),   64'd0);
    chk("rst_tick",      64'(m_tick),  64'd0);
    chk("rst_audio_out", 64'(m_out),   64'd0);
    chk("rst_level",     64'(m_level), 64'd0);
    chk("rst_in_ready",  64'(m_ready), 64'd1);
    chk("rst_underrun",  64'(m_under), 64'd0);
    chk("rst_overflow",  64'(m_over),  64'd0);
    reset = 1'b0;

    // ---- phase pattern and long-run rate over 1000 edges
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (e <= 13) begin
        ph_clk[e-1]  = p_clk;
        ph_tick[e-1] = p_tick;
      end
      if (p_clk != prev_p) begin
        p_tog++;
        if (p_last != 0 && (e - p_last) > p_gap) p_gap = e - p_last;
        p_last = e;
      end
      if (m_clk != prev_m) begin
        m_tog++;
        if (m_last != 0 && (e - m_last) > m_gap) m_gap = e - m_last;
        m_last = e;
      end
      prev_p = p_clk;
      prev_m = m_clk;
      if (p_tick) p_ticks++;
      if (m_tick) m_ticks++;
    end
    // clk_audio high after edges 3,4,8,9,13; ticks at edges 3,8,13 (bit0 = edge 1)
    chk("phase_clk_pattern",  64'(ph_clk),  64'h118C);
    chk("phase_tick_pattern", 64'(ph_tick), 64'h1084);
    chk("phase_toggles",      64'(p_tog),   64'd400);
    chk("phase_ticks",        64'(p_ticks), 64'd200);
    chk("phase_max_gap",      64'(p_gap),   64'd3);
    chk("main_toggles",       64'(m_tog),   64'd40);
    chk("main_ticks",         64'(m_ticks), 64'd20);
    chk("main_max_gap",       64'(m_gap),   64'd25);
    chk("idle_underrun",      64'(m_under), 64'd1);
    chk("idle_out_zero",      64'(m_out),   64'd0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_underrun", 64'(m_under), 64'd0);

    // ---- ordering and 16->24 width conversion
    push({16'h8001, 16'h1234});
    push({16'h0001, 16'h7FFF});
    chk("order_level2", 64'(m_level), 64'd2);
    wait_tick("order_a");
    chk("order_a_out",   64'(m_out),   64'(w24(16'h8001, 16'h1234)));
    chk("order_a_level", 64'(m_level), 64'd1);
    wait_tick("order_b");
    chk("order_b_out",   64'(m_out),   64'(w24(16'h0001, 16'h7FFF)));
    chk("order_b_level", 64'(m_level), 64'd0);
    chk("order_no_under", 64'(m_under), 64'd0);

    // ---- underrun: repeat last vs zero fill
    push({16'h1111, 16'hABCD});
    wait_tick("ur_fill");
    chk("ur_fill_out",   64'(m_out),   64'(w24(16'h1111, 16'hABCD)));
    chk("ur_fill_flag",  64'(m_under), 64'd0);
    wait_tick("ur_empty");
    chk("ur_repeat_out", 64'(m_out),   64'(w24(16'h1111, 16'hABCD)));
    chk("ur_flag",       64'(m_under), 64'd1);
    chk("ur_zero_tick",  64'(z_tick),  64'd1);
    chk("ur_zero_out",   64'(z_out),   64'd0);
    chk("ur_zero_flag",  64'(z_under), 64'd1);

    // ---- overflow
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_clr_under", 64'(m_under), 64'd0);
    for (int i = 0; i < 4; i++) push({16'hF000 + 16'(i), 16'h1000 + 16'(i)});
    chk("ovf_ready_full", 64'(m_ready), 64'd0);
    chk("ovf_level_full", 64'(m_level), 64'd4);
    chk("ovf_not_yet",    64'(m_over),  64'd0);
    push({16'hF004, 16'h1004});
    chk("ovf_flag",       64'(m_over),  64'd1);
    chk("ovf_level_held", 64'(m_level), 64'd4);
    in_valid = 1'b1; clr_flags = 1'b1;
    step();
    in_valid = 1'b0; clr_flags = 1'b0;
    chk("ovf_set_wins", 64'(m_over), 64'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_cleared", 64'(m_over), 64'd0);

    // ---- mute drains the FIFO while outputting zero
    mute = 1'b1;
    wait_tick("mute1");
    chk("mute1_out",   64'(m_out),   64'd0);
    chk("mute1_level", 64'(m_level), 64'd3);
    wait_tick("mute2");
    chk("mute2_out",   64'(m_out),   64'd0);
    chk("mute2_level", 64'(m_level), 64'd2);
    mute = 1'b0;
    wait_tick("unmute1");
    chk("unmute1_out",   64'(m_out),   64'(w24(16'hF002, 16'h1002)));
    chk("unmute1_level", 64'(m_level), 64'd1);
    wait_tick("unmute2");
    chk("unmute2_out",   64'(m_out),   64'(w24(16'hF003, 16'h1003)));
    chk("unmute2_level", 64'(m_level), 64'd0);

    // ---- push on the very tick edge with an empty FIFO: not visible yet
    repeat (49) step();
    in_valid = 1'b1;
    in_data  = {16'h2222, 16'h5555};
    step();
    in_valid = 1'b0;
    chk("lat_tick",   64'(m_tick),  64'd1);
    chk("lat_out",    64'(m_out),   64'(w24(16'hF003, 16'h1003)));
    chk("lat_under",  64'(m_under), 64'd1);
    chk("lat_level",  64'(m_level), 64'd1);
    wait_tick("lat_next");
    chk("lat_next_out",   64'(m_out),   64'(w24(16'h2222, 16'h5555)));
    chk("lat_next_level", 64'(m_level), 64'd0);

    // ---- reset mid-run
    push({16'h3333, 16'h4444});
    chk("mid_pre_clk", 64'(m_clk), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_clk_audio", 64'(m_clk),   64'd0);
    chk("mid_audio_out", 64'(m_out),   64'd0);
    chk("mid_level",     64'(m_level), 64'd0);
    chk("mid_tick",      64'(m_tick),  64'd0);
    chk("mid_ready",     64'(m_ready), 64'd1);
    chk("mid_underrun",  64'(m_under), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
